// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared register-file widths and writeback source encoding
package rv32i_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy vector for pending destination registers
module rf_scoreboard #(
   parameter int AW = rv32i_pkg::ADDR_W,
   parameter int NR = 2 ** AW
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          set_en_i,
   input  logic [AW-1:0] set_addr_i,
   input  logic          clr_en_i,
   input  logic [AW-1:0] clr_addr_i,
   input  logic [AW-1:0] q1_addr_i,
   input  logic [AW-1:0] q2_addr_i,
   output logic          q1_busy_o,
   output logic          q2_busy_o,
   output logic          err_o
);
   import rv32i_pkg::*;

   logic [NR-1:0] busy_q, busy_d;
   logic          err_q, err_d;

   // Clear first so a same-edge set of the committing register wins.
   always_comb begin
      busy_d = busy_q;
      err_d  = 1'b0;
      if (clr_en_i) begin
         busy_d[clr_addr_i] = 1'b0;
      end
      if (set_en_i && (set_addr_i != '0)) begin
         busy_d[set_addr_i] = 1'b1;
         err_d = busy_q[set_addr_i] && !(clr_en_i && (clr_addr_i == set_addr_i));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign q1_busy_o = (q1_addr_i != '0) && busy_q[q1_addr_i];
   assign q2_busy_o = (q2_addr_i != '0) && busy_q[q2_addr_i];
   assign err_o     = err_q;
endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - arbitrates ALU/LSU writebacks onto the register file write port
module rf_wb_scheduler #(
   parameter int DATA_W = rv32i_pkg::DATA_W,
   parameter int ADDR_W = rv32i_pkg::ADDR_W,
   parameter int RR_EN  = 1
) (
   input  logic              sysclk,
   input  logic              sysreset,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   output logic              iss_err,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] q_rs1,
   input  logic [ADDR_W-1:0] q_rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_rd_addr,
   output logic [DATA_W-1:0] rf_rd_data
);
   import rv32i_pkg::*;

   src_e              ptr_q, ptr_d;
   logic              grant_alu, grant_lsu, xfer_we;
   logic [ADDR_W-1:0] xfer_rd;
   logic [DATA_W-1:0] xfer_data;
   logic              rf_we_q;
   logic [ADDR_W-1:0] rf_rd_addr_q;
   logic [DATA_W-1:0] rf_rd_data_q;

   // Nothing is granted while in reset, so no transfer can leak past it.
   always_comb begin
      grant_alu = 1'b0;
      grant_lsu = 1'b0;
      ptr_d     = ptr_q;
      if (!sysreset) begin
         if (alu_valid && lsu_valid) begin
            if ((RR_EN != 0) && (ptr_q == SRC_ALU)) begin
               grant_alu = 1'b1;
               ptr_d     = SRC_LSU;
            end else begin
               grant_lsu = 1'b1;
               if (RR_EN != 0) begin
                  ptr_d = SRC_ALU;
               end
            end
         end else begin
            grant_alu = alu_valid;
            grant_lsu = lsu_valid;
         end
      end
      xfer_rd   = grant_lsu ? lsu_rd : alu_rd;
      xfer_data = grant_lsu ? lsu_data : alu_data;
      xfer_we   = (grant_alu || grant_lsu) && (xfer_rd != '0);
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         ptr_q        <= SRC_ALU;
         rf_we_q      <= 1'b0;
         rf_rd_addr_q <= '0;
         rf_rd_data_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         rf_we_q <= xfer_we;
         if (xfer_we) begin
            rf_rd_addr_q <= xfer_rd;
            rf_rd_data_q <= xfer_data;
         end
      end
   end

   assign alu_ready  = grant_alu;
   assign lsu_ready  = grant_lsu;
   assign rf_we      = rf_we_q;
   assign rf_rd_addr = rf_rd_addr_q;
   assign rf_rd_data = rf_rd_data_q;

   rf_scoreboard #(.AW(ADDR_W)) u_scoreboard (
      .clk_i      (sysclk),
      .rst_i      (sysreset),
      .set_en_i   (iss_valid),
      .set_addr_i (iss_rd),
      .clr_en_i   (rf_we_q),
      .clr_addr_i (rf_rd_addr_q),
      .q1_addr_i  (q_rs1),
      .q2_addr_i  (q_rs2),
      .q1_busy_o  (rs1_busy),
      .q2_busy_o  (rs2_busy),
      .err_o      (iss_err)
   );
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - randomized bench for round-robin and fixed-priority instances
module tb_rf_wb_scheduler;
   logic sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // index 0: RR_EN=1, index 1: RR_EN=0
   logic [1:0] rst, iss_valid, iss_err, alu_valid, alu_ready, lsu_valid, lsu_ready;
   logic [1:0] rs1_busy, rs2_busy, rf_we;
   logic [4:0]  iss_rd [2], alu_rd [2], lsu_rd [2], q_rs1 [2], q_rs2 [2], rf_rd_addr [2];
   logic [31:0] alu_data [2], lsu_data [2], rf_rd_data [2];

   rf_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .RR_EN(1)) u_rr (
      .sysclk(sysclk), .sysreset(rst[0]),
      .iss_valid(iss_valid[0]), .iss_rd(iss_rd[0]), .iss_err(iss_err[0]),
      .alu_valid(alu_valid[0]), .alu_rd(alu_rd[0]), .alu_data(alu_data[0]), .alu_ready(alu_ready[0]),
      .lsu_valid(lsu_valid[0]), .lsu_rd(lsu_rd[0]), .lsu_data(lsu_data[0]), .lsu_ready(lsu_ready[0]),
      .q_rs1(q_rs1[0]), .q_rs2(q_rs2[0]), .rs1_busy(rs1_busy[0]), .rs2_busy(rs2_busy[0]),
      .rf_we(rf_we[0]), .rf_rd_addr(rf_rd_addr[0]), .rf_rd_data(rf_rd_data[0])
   );

   rf_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .RR_EN(0)) u_fp (
      .sysclk(sysclk), .sysreset(rst[1]),
      .iss_valid(iss_valid[1]), .iss_rd(iss_rd[1]), .iss_err(iss_err[1]),
      .alu_valid(alu_valid[1]), .alu_rd(alu_rd[1]), .alu_data(alu_data[1]), .alu_ready(alu_ready[1]),
      .lsu_valid(lsu_valid[1]), .lsu_rd(lsu_rd[1]), .lsu_data(lsu_data[1]), .lsu_ready(lsu_ready[1]),
      .q_rs1(q_rs1[1]), .q_rs2(q_rs2[1]), .rs1_busy(rs1_busy[1]), .rs2_busy(rs2_busy[1]),
      .rf_we(rf_we[1]), .rf_rd_addr(rf_rd_addr[1]), .rf_rd_data(rf_rd_data[1])
   );

   // Reference model: pending-register set plus the one write in flight.
   bit          m_busy [2][32];
   bit          m_alu_turn [2];
   bit          m_we [2];
   logic [4:0]  m_addr [2];
   logic [31:0] m_data [2];
   bit          m_err [2];
   bit          alu_hold [2], lsu_hold [2];
   bit          g_alu [2], g_lsu [2];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int k);
      for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
      m_alu_turn[k] = 1'b1;
      m_we[k]       = 1'b0;
      m_addr[k]     = '0;
      m_data[k]     = '0;
      m_err[k]      = 1'b0;
      alu_hold[k]   = 1'b0;
      lsu_hold[k]   = 1'b0;
   endtask

   task automatic decide_grants(input int k);
      g_alu[k] = 1'b0;
      g_lsu[k] = 1'b0;
      if (!rst[k]) begin
         if (alu_valid[k] && lsu_valid[k]) begin
            if (k == 0 && m_alu_turn[k]) g_alu[k] = 1'b1;
            else                         g_lsu[k] = 1'b1;
         end else begin
            g_alu[k] = alu_valid[k];
            g_lsu[k] = lsu_valid[k];
         end
      end
   endtask

   task automatic model_edge(input int k);
      bit err;
      if (rst[k]) begin
         model_reset(k);
         return;
      end
      err = iss_valid[k] && iss_rd[k] != 0 && m_busy[k][iss_rd[k]] &&
            !(m_we[k] && m_addr[k] == iss_rd[k]);
      if (m_we[k]) m_busy[k][m_addr[k]] = 1'b0;
      if (iss_valid[k] && iss_rd[k] != 0) m_busy[k][iss_rd[k]] = 1'b1;
      m_err[k] = err;
      m_we[k]  = 1'b0;
      if (g_alu[k] && alu_rd[k] != 0) begin
         m_we[k] = 1'b1; m_addr[k] = alu_rd[k]; m_data[k] = alu_data[k];
      end
      if (g_lsu[k] && lsu_rd[k] != 0) begin
         m_we[k] = 1'b1; m_addr[k] = lsu_rd[k]; m_data[k] = lsu_data[k];
      end
      if (k == 0 && alu_valid[k] && lsu_valid[k]) m_alu_turn[k] = g_lsu[k];
      alu_hold[k] = alu_valid[k] && !g_alu[k];
      lsu_hold[k] = lsu_valid[k] && !g_lsu[k];
   endtask

   // Entered just after a falling edge with inputs already driven.
   task automatic run_cycle();
      #1;
      for (int k = 0; k < 2; k++) begin
         decide_grants(k);
         check_val($sformatf("u%0d_alu_ready", k), 32'(alu_ready[k]), 32'(g_alu[k]));
         check_val($sformatf("u%0d_lsu_ready", k), 32'(lsu_ready[k]), 32'(g_lsu[k]));
         check_val($sformatf("u%0d_rf_we", k), 32'(rf_we[k]), 32'(m_we[k]));
         check_val($sformatf("u%0d_rf_rd_addr", k), 32'(rf_rd_addr[k]), 32'(m_addr[k]));
         check_val($sformatf("u%0d_rf_rd_data", k), rf_rd_data[k], m_data[k]);
         check_val($sformatf("u%0d_iss_err", k), 32'(iss_err[k]), 32'(m_err[k]));
         check_val($sformatf("u%0d_rs1_busy", k), 32'(rs1_busy[k]), 32'(m_busy[k][q_rs1[k]]));
         check_val($sformatf("u%0d_rs2_busy", k), 32'(rs2_busy[k]), 32'(m_busy[k][q_rs2[k]]));
      end
      @(posedge sysclk);
      for (int k = 0; k < 2; k++) model_edge(k);
      @(negedge sysclk);
   endtask

   task automatic drive_all(input bit r, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                            input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                            input bit iv, input logic [4:0] ir, input logic [4:0] q1);
      for (int k = 0; k < 2; k++) begin
         rst[k] = r; alu_valid[k] = av; alu_rd[k] = ar; alu_data[k] = ad;
         lsu_valid[k] = lv; lsu_rd[k] = lr; lsu_data[k] = ld;
         iss_valid[k] = iv; iss_rd[k] = ir; q_rs1[k] = q1; q_rs2[k] = ir;
      end
   endtask

   task automatic drive_random(input int k);
      rst[k] = ($urandom_range(0, 49) == 0);
      if (!alu_hold[k]) begin
         alu_valid[k] = ($urandom_range(0, 9) < 6);
         alu_rd[k]    = 5'($urandom_range(0, 7));
         alu_data[k]  = $urandom;
      end
      if (!lsu_hold[k]) begin
         lsu_valid[k] = ($urandom_range(0, 9) < 6);
         lsu_rd[k]    = 5'($urandom_range(0, 7));
         lsu_data[k]  = $urandom;
      end
      iss_valid[k] = ($urandom_range(0, 9) < 4);
      iss_rd[k]    = 5'($urandom_range(0, 7));
      q_rs1[k]     = 5'($urandom_range(0, 7));
      q_rs2[k]     = 5'($urandom_range(0, 7));
   endtask

   initial begin
      for (int k = 0; k < 2; k++) model_reset(k);
      drive_all(1'b1, 1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 5'd0, 5'd0);
      @(negedge sysclk);
      run_cycle();
      run_cycle();
      drive_all(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5);
      run_cycle();
      drive_all(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5);
      run_cycle();
      check_val("dir_single_addr", 32'(rf_rd_addr[0]), 32'd5);
      check_val("dir_single_data", rf_rd_data[0], 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin
         drive_all(1'b0, 1'b1, 5'd1, 32'hA000_0000 + i, 1'b1, 5'd2, 32'hB000_0000 + i, 1'b0, 5'd0, 5'd0);
         run_cycle();
      end
      drive_all(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
      run_cycle();
      drive_all(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777_7777, 1'b0, 5'd0, 5'd7);
      run_cycle();
      drive_all(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
      run_cycle();
      drive_all(1'b0, 1'b1, 5'd0, 32'hFFFF_0000, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
      run_cycle();
      drive_all(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
      run_cycle();
      drive_all(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7);
      run_cycle();
      drive_all(1'b1, 1'b1, 5'd4, 32'h4444_4444, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3);
      run_cycle();
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 2; k++) drive_random(k);
         run_cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
